// File: rtl/handshake_fifo.sv
// Elastic req/ack buffer: consumer-style handshake on the left, producer-style
// handshake with one-cycle ack pulses on the right, circular storage in between.
module handshake_fifo #(
  parameter int data_width = 32,
  parameter int depth      = 4,
  localparam int aw        = $clog2(depth)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  req_l,
  input  logic                  ack_l,
  input  logic [data_width-1:0] din,
  input  logic                  req_r,
  output logic                  ack_r,
  output logic [data_width-1:0] dout,
  output logic [aw:0]           count,
  output logic                  overflow
);

  localparam logic [aw:0] full_count = (aw+1)'(depth);

  logic [data_width-1:0] mem [depth];
  logic [aw-1:0]         wr_ptr;
  logic [aw-1:0]         rd_ptr;
  logic                  rd_en;
  logic                  wr_en;
  logic [aw:0]           count_next;

  // A read on the same edge frees a slot, so a write into a full buffer is still taken.
  always_comb begin
    rd_en      = req_r && !ack_r && (count != '0);
    wr_en      = ack_l && ((count != full_count) || rd_en);
    count_next = count;
    if (wr_en && !rd_en) begin
      count_next = count + 1'b1;
    end else if (rd_en && !wr_en) begin
      count_next = count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      req_l    <= 1'b0;
      ack_r    <= 1'b0;
      dout     <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
        dout   <= mem[rd_ptr];
      end
      ack_r <= rd_en;
      count <= count_next;
      // Request is withdrawn during the ack cycle so each item takes two cycles.
      req_l <= (count_next < full_count) && !ack_l;
      if (ack_l && !wr_en) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: tb/tb_handshake_fifo.sv
// Bench for handshake_fifo: directed vector table, hand-written corner sequences,
// random streams against a queue-based reference, plus depth 2 and depth 8 copies.
module tb_handshake_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ack_l = 1'b0;
  logic        req_r = 1'b0;
  logic [31:0] din = '0;
  logic        req_l;
  logic        ack_r;
  logic [31:0] dout;
  logic [2:0]  count;
  logic        overflow;

  int checks = 0;
  int failures = 0;
  int tx_next = 0;
  int rx_next = 0;
  logic bg_rst = 1'b0;

  always #5 clk = ~clk;

  handshake_fifo #(.data_width(32), .depth(4)) dut (
    .clk(clk), .rst(rst), .req_l(req_l), .ack_l(ack_l), .din(din),
    .req_r(req_r), .ack_r(ack_r), .dout(dout), .count(count), .overflow(overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a plain queue of accepted items, advanced on every rising edge.
  int unsigned q[$];
  logic        m_ack_r = 1'b0;
  logic        m_ovf = 1'b0;
  logic        m_req_l = 1'b0;
  logic [31:0] m_dout = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      m_ack_r = 1'b0;
      m_ovf   = 1'b0;
      m_req_l = 1'b0;
      m_dout  = '0;
    end else begin
      bit rd;
      bit wr;
      rd = req_r && !m_ack_r && (q.size() > 0);
      wr = ack_l && ((q.size() < 4) || rd);
      if (ack_l && !wr) m_ovf = 1'b1;
      m_ack_r = rd;
      if (rd) m_dout = q.pop_front();
      if (wr) q.push_back(din);
      m_req_l = (q.size() < 4) && !ack_l;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      check("model req_l", 32'(req_l), 32'(m_req_l));
      check("model ack_r", 32'(ack_r), 32'(m_ack_r));
      check("model count", 32'(count), q.size());
      check("model dout", dout, m_dout);
      check("model overflow", 32'(overflow), 32'(m_ovf));
    end
  end

  typedef struct {
    logic        a;
    logic [31:0] d;
    logic        r;
    logic        e_req_l;
    logic        e_ack_r;
    logic [2:0]  e_count;
    logic [31:0] e_dout;
    logic        e_ovf;
  } vec_t;

  vec_t vecs[26];

  function automatic vec_t mk(logic a, int d, logic r, logic rl, logic ar, int c, int dd);
    vec_t v;
    v.a = a; v.d = 32'(d); v.r = r;
    v.e_req_l = rl; v.e_ack_r = ar; v.e_count = 3'(c); v.e_dout = 32'(dd); v.e_ovf = 1'b0;
    return v;
  endfunction

  task automatic apply_cycle(input logic a, input logic [31:0] d, input logic r);
    ack_l = a;
    din   = d;
    req_r = r;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] val);
    apply_cycle(1'b1, val, 1'b0);
    apply_cycle(1'b0, '0, 1'b0);
  endtask

  // Source acks whenever it sees a request (unless it stalls); sink requests randomly.
  task automatic run_stream(input int target, input int fail, input string tag);
    int budget;
    budget = (target - rx_next) * 12 + 200;
    while (rx_next < target && budget > 0) begin
      if (req_l && !ack_l && tx_next < target && $urandom_range(99) >= 32'(fail)) begin
        ack_l = 1'b1;
        din   = 32'(tx_next);
        tx_next++;
      end else begin
        ack_l = 1'b0;
      end
      req_r = ($urandom_range(99) >= 32'(fail));
      @(posedge clk);
      #1;
      if (ack_r) begin
        check({tag, " order"}, dout, 32'(rx_next));
        rx_next++;
      end
      check({tag, " count bound"}, 32'(count <= 3'd4), 32'd1);
      budget--;
    end
    check({tag, " received"}, 32'(rx_next), 32'(target));
    ack_l = 1'b0;
    req_r = 1'b0;
  endtask

  initial begin
    bg_rst = 1'b0;
    #23 bg_rst = 1'b1;
  end

  // Independent depth 2 and depth 8 instances streaming with 30% stalls on both sides.
  for (genvar g = 0; g < 2; g++) begin : g_rand
    localparam int D  = (g == 0) ? 2 : 8;
    localparam int AW = $clog2(D);
    logic          b_req_l;
    logic          b_ack_l = 1'b0;
    logic          b_req_r = 1'b0;
    logic          b_ack_r;
    logic          b_ovf;
    logic [31:0]   b_din = '0;
    logic [31:0]   b_dout;
    logic [AW:0]   b_count;
    int            b_tx = 0;
    int            b_rx = 0;
    bit            b_done = 1'b0;

    handshake_fifo #(.data_width(32), .depth(D)) u_fifo (
      .clk(clk), .rst(bg_rst), .req_l(b_req_l), .ack_l(b_ack_l), .din(b_din),
      .req_r(b_req_r), .ack_r(b_ack_r), .dout(b_dout), .count(b_count), .overflow(b_ovf)
    );

    initial begin
      @(posedge bg_rst);
      for (int cyc = 0; cyc < 6000 && b_rx < 300; cyc++) begin
        @(posedge clk);
        #1;
        if (b_ack_r) begin
          check($sformatf("depth%0d order", D), b_dout, 32'(b_rx));
          b_rx++;
        end
        check($sformatf("depth%0d count bound", D), 32'(32'(b_count) <= D), 32'd1);
        if (b_req_l && !b_ack_l && b_tx < 300 && $urandom_range(99) >= 30) begin
          b_ack_l = 1'b1;
          b_din   = 32'(b_tx);
          b_tx++;
        end else begin
          b_ack_l = 1'b0;
        end
        b_req_r = ($urandom_range(99) >= 30);
      end
      check($sformatf("depth%0d received", D), 32'(b_rx), 32'd300);
      check($sformatf("depth%0d overflow", D), 32'(b_ovf), 32'd0);
      b_done = 1'b1;
    end
  end

  initial begin
    #2000000;
    failures++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    vecs[0]  = mk(0, 0, 0, 1, 0, 0, 0);
    vecs[1]  = mk(1, 0, 0, 0, 0, 1, 0);
    vecs[2]  = mk(0, 0, 0, 1, 0, 1, 0);
    vecs[3]  = mk(1, 1, 0, 0, 0, 2, 0);
    vecs[4]  = mk(0, 0, 0, 1, 0, 2, 0);
    vecs[5]  = mk(1, 2, 0, 0, 0, 3, 0);
    vecs[6]  = mk(0, 0, 0, 1, 0, 3, 0);
    vecs[7]  = mk(1, 3, 0, 0, 0, 4, 0);
    vecs[8]  = mk(0, 0, 0, 0, 0, 4, 0);
    vecs[9]  = mk(0, 0, 0, 0, 0, 4, 0);
    vecs[10] = mk(0, 0, 1, 1, 1, 3, 0);
    vecs[11] = mk(1, 4, 1, 0, 0, 4, 0);
    vecs[12] = mk(0, 0, 1, 1, 1, 3, 1);
    vecs[13] = mk(1, 5, 1, 0, 0, 4, 1);
    vecs[14] = mk(0, 0, 1, 1, 1, 3, 2);
    vecs[15] = mk(1, 6, 1, 0, 0, 4, 2);
    vecs[16] = mk(0, 0, 1, 1, 1, 3, 3);
    vecs[17] = mk(0, 0, 1, 1, 0, 3, 3);
    vecs[18] = mk(0, 0, 1, 1, 1, 2, 4);
    vecs[19] = mk(0, 0, 1, 1, 0, 2, 4);
    vecs[20] = mk(0, 0, 1, 1, 1, 1, 5);
    vecs[21] = mk(0, 0, 1, 1, 0, 1, 5);
    vecs[22] = mk(0, 0, 1, 1, 1, 0, 6);
    vecs[23] = mk(0, 0, 1, 1, 0, 0, 6);
    vecs[24] = mk(1, 7, 1, 0, 0, 1, 6);
    vecs[25] = mk(0, 0, 1, 1, 1, 0, 7);

    repeat (3) @(posedge clk);
    #1;
    check("reset req_l", 32'(req_l), 32'd0);
    check("reset ack_r", 32'(ack_r), 32'd0);
    check("reset count", 32'(count), 32'd0);
    check("reset dout", dout, 32'd0);
    check("reset overflow", 32'(overflow), 32'd0);
    rst = 1'b1;

    // Fill to full with the sink idle, then drain at one item per two cycles.
    for (int i = 0; i < 26; i++) begin
      apply_cycle(vecs[i].a, vecs[i].d, vecs[i].r);
      check($sformatf("vec%0d req_l", i), 32'(req_l), 32'(vecs[i].e_req_l));
      check($sformatf("vec%0d ack_r", i), 32'(ack_r), 32'(vecs[i].e_ack_r));
      check($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].e_count));
      check($sformatf("vec%0d dout", i), dout, vecs[i].e_dout);
      check($sformatf("vec%0d overflow", i), 32'(overflow), 32'(vecs[i].e_ovf));
    end

    // Forced ack while full must be dropped without touching the head entry.
    for (int v = 8; v < 12; v++) push(32'(v));
    check("full count", 32'(count), 32'd4);
    check("full req_l", 32'(req_l), 32'd0);
    apply_cycle(1'b1, 32'hdead_beef, 1'b0);
    check("ovf set", 32'(overflow), 32'd1);
    check("ovf count", 32'(count), 32'd4);
    apply_cycle(1'b0, '0, 1'b0);
    check("ovf sticky", 32'(overflow), 32'd1);
    apply_cycle(1'b0, '0, 1'b1);
    check("ovf head ack", 32'(ack_r), 32'd1);
    check("ovf head dout", dout, 32'd8);
    apply_cycle(1'b0, '0, 1'b1);
    check("ovf no double ack", 32'(ack_r), 32'd0);
    apply_cycle(1'b0, '0, 1'b1);
    check("ovf second dout", dout, 32'd9);
    check("ovf still sticky", 32'(overflow), 32'd1);

    #2 rst = 1'b0;
    #1;
    check("reset clears ovf", 32'(overflow), 32'd0);
    check("reset clears count", 32'(count), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    tx_next = 0;
    rx_next = 0;
    run_stream(5000, 0, "stream5000");
    check("stream overflow", 32'(overflow), 32'd0);

    // Asynchronous reset while partially full discards the buffered items.
    apply_cycle(1'b0, '0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      push(32'(tx_next));
      tx_next++;
    end
    check("pre-reset count", 32'(count), 32'd3);
    #2 rst = 1'b0;
    #1;
    check("async reset count", 32'(count), 32'd0);
    check("async reset ack_r", 32'(ack_r), 32'd0);
    check("async reset req_l", 32'(req_l), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    apply_cycle(1'b0, '0, 1'b0);
    check("post-reset req_l", 32'(req_l), 32'd1);
    check("post-reset count", 32'(count), 32'd0);
    rx_next = tx_next;
    run_stream(tx_next + 300, 30, "random4");
    check("random4 overflow", 32'(overflow), 32'd0);

    for (int i = 0; i < 7000 && !(g_rand[0].b_done && g_rand[1].b_done); i++) @(posedge clk);
    check("depth2 finished", 32'(g_rand[0].b_done), 32'd1);
    check("depth8 finished", 32'(g_rand[1].b_done), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
